pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
//  Drives the control inputs of the MIPS pipeline stage registers: freeze, flush and hazard_detected_signal.
//  Detects load-use and RAW hazards at ID, branch flushes from EXE, and multi-cycle data-memory waits at MEM.
//  Memory waits are tracked by a wait-state FSM with a timeout.
//  Keeps saturating stall/flush event counters for debug.
// PARAMETERS
//  FORWARD_EN   1    1: only load-use stalls (forwarding unit present); 0: stall on any RAW vs EXE/MEM dest
//  MEM_TIMEOUT  255  max consecutive wait cycles at MEM before the error state (1..255)
//  CNT_W        16   width of the stall_cnt and flush_cnt counters
// PORTS
//  clk                     in   1      clock, all state on posedge
//  rst                     in   1      asynchronous, active-low reset
//  ID_src1, ID_src2        in   5      source register numbers of the instruction in ID
//  ID_two_src              in   1      1: ID_src2 is a real operand (R-type, store, branch)
//  EXE_dest, MEM_dest      in   5      destination registers in EXE / MEM
//  EXE_WB_en, MEM_WB_en    in   1      write-back enables of the EXE / MEM instructions
//  EXE_MEM_read            in   1      the EXE instruction is a load
//  br_taken                in   1      branch resolved taken in EXE
//  mem_req                 in   1      MEM stage holds a load/store (MEM_read|MEM_write)
//  mem_ready               in   1      data memory completes the access this cycle
//  freeze                  out  1      hold PC and the IF/ID register
//  flush                   out  1      clear the IF/ID register
//  hazard_detected_signal  out  1      insert a bubble into the ID/EXE register
//  mem_stall               out  1      hold the EXE/MEM and MEM/WB registers and the PC
//  mem_err                 out  1      sticky timeout flag
//  stall_cnt, flush_cnt    out  CNT_W  saturating event counters
// BEHAVIOUR
//  Reset (rst=0, async): state=RUN, wait_cnt=0, mem_err=0, stall_cnt=0, flush_cnt=0.
//   All combinational outputs evaluate to 0 while no request is active.
//  Matching: register 0 never matches. src2 is compared only when ID_two_src=1.
//  raw_ld = EXE_MEM_read & EXE_WB_en & (src match EXE_dest).
//  raw_any = raw_ld | (EXE_WB_en & match EXE_dest) | (MEM_WB_en & match MEM_dest).
//  raw = FORWARD_EN ? raw_ld : raw_any.
//  FSM states RUN, WAIT, ERR (2-bit state register):
//   RUN:  mem_req & ~mem_ready -> WAIT, wait_cnt<=1. Otherwise stay in RUN.
//   WAIT: mem_ready -> RUN, wait_cnt<=0.
//         Else if wait_cnt==MEM_TIMEOUT -> ERR and mem_err<=1.
//         Else wait_cnt<=wait_cnt+1.
//   ERR:  sticky until reset; stall is released, so the pipeline proceeds with undefined load data.
//  mem_stall = (RUN & mem_req & ~mem_ready) | (WAIT & ~mem_ready). Combinational, same cycle.
//  Output priority, evaluated combinationally each cycle:
//   1) mem_stall=1: freeze=1, flush=0, hazard_detected_signal=0.
//      The whole pipe holds; br_taken and raw are deferred (they re-evaluate once the stall is released).
//   2) br_taken: flush=1, hazard_detected_signal=1, freeze=0. The wrong-path IF and ID instructions are killed.
//   3) raw: freeze=1, hazard_detected_signal=1, flush=0.
//   4) otherwise: all 0.
//  Latency: a hazard is asserted in the same cycle its inputs present it; no registered delay.
//  stall_cnt +1 on every cycle with freeze=1; flush_cnt +1 on every cycle with flush=1.
//   Both counters saturate at all-ones and never wrap.
//  mem_ready in RUN with no prior wait: no state change and no stall.
//   mem_ready with mem_req=0 is ignored.
//  Reset asserted mid-WAIT: returns to RUN immediately and clears wait_cnt.
// TESTING
//  1) Load r5 in EXE (EXE_MEM_read=1, EXE_dest=5), ID_src1=5
//     -> freeze=1, hazard=1, flush=0 for 1 cycle; stall_cnt=1.
//  2) FORWARD_EN=0, MEM_WB_en=1, MEM_dest=3, ID_src2=3, ID_two_src=1 -> freeze=hazard=1.
//     Same stimulus with ID_two_src=0 -> all 0.
//     Any src=0 against dest=0 -> no hazard.
//  3) br_taken=1 together with a load-use hazard -> flush=1, hazard=1, freeze=0; flush_cnt=1.
//  4) mem_req=1, mem_ready low for 3 cycles then high -> mem_stall=1 for 3 cycles.
//     FSM returns to RUN; a load-use hazard present throughout is asserted only after the stall.
//  5) MEM_TIMEOUT=4, mem_ready held low -> ERR after 4 WAIT cycles; mem_err=1 sticky; mem_stall=0.
//  6) Counter saturation (CNT_W=4, 20 stall cycles) -> stall_cnt=15.
//     Async reset pulse mid-WAIT -> outputs 0 and state=RUN with no clock edge.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : Pipeline-side signal bundle for the hazard controller.
// Revision : 1.0
// ============================================================================
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       ID_src1;
    logic [4:0]       ID_src2;
    logic             ID_two_src;
    logic [4:0]       EXE_dest;
    logic [4:0]       MEM_dest;
    logic             EXE_WB_en;
    logic             MEM_WB_en;
    logic             EXE_MEM_read;
    logic             br_taken;
    logic             mem_req;
    logic             mem_ready;
    logic             freeze;
    logic             flush;
    logic             hazard_detected_signal;
    logic             mem_stall;
    logic             mem_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output ID_src1, ID_src2, ID_two_src, EXE_dest, MEM_dest,
               EXE_WB_en, MEM_WB_en, EXE_MEM_read, br_taken, mem_req, mem_ready,
        input  freeze, flush, hazard_detected_signal, mem_stall, mem_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  ID_src1, ID_src2, ID_two_src, EXE_dest, MEM_dest,
               EXE_WB_en, MEM_WB_en, EXE_MEM_read, br_taken, mem_req, mem_ready,
        output freeze, flush, hazard_detected_signal, mem_stall, mem_err,
               stall_cnt, flush_cnt
    );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : MIPS pipeline freeze/flush/bubble control with memory wait FSM.
// Revision : 1.0
// ============================================================================
module pipe_hazard_ctrl #(
    parameter int FORWARD_EN  = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    localparam logic [7:0]       c_TIMEOUT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    state_t           r_state;
    logic [7:0]       r_wait_cnt;
    logic             r_mem_err;
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;

    logic w_s1_exe, w_s2_exe, w_s1_mem, w_s2_mem;
    logic w_hit_exe, w_hit_mem;
    logic w_raw_ld, w_raw_any, w_raw;
    logic w_mem_stall, w_freeze, w_flush, w_hazard;

    // Register 0 is hardwired to zero, so it can never carry a dependency.
    assign w_s1_exe = (hz.ID_src1 != 5'd0) && (hz.ID_src1 == hz.EXE_dest);
    assign w_s2_exe = hz.ID_two_src && (hz.ID_src2 != 5'd0) && (hz.ID_src2 == hz.EXE_dest);
    assign w_s1_mem = (hz.ID_src1 != 5'd0) && (hz.ID_src1 == hz.MEM_dest);
    assign w_s2_mem = hz.ID_two_src && (hz.ID_src2 != 5'd0) && (hz.ID_src2 == hz.MEM_dest);

    assign w_hit_exe = hz.EXE_WB_en & (w_s1_exe | w_s2_exe);
    assign w_hit_mem = hz.MEM_WB_en & (w_s1_mem | w_s2_mem);
    assign w_raw_ld  = hz.EXE_MEM_read & w_hit_exe;
    assign w_raw_any = w_raw_ld | w_hit_exe | w_hit_mem;
    assign w_raw     = (FORWARD_EN != 0) ? w_raw_ld : w_raw_any;

    assign w_mem_stall = ((r_state == ST_RUN)  & hz.mem_req & ~hz.mem_ready) |
                         ((r_state == ST_WAIT) & ~hz.mem_ready);

    // A memory stall holds the whole pipe, so branch and RAW are deferred.
    assign w_freeze = w_mem_stall | (~hz.br_taken & w_raw);
    assign w_flush  = ~w_mem_stall & hz.br_taken;
    assign w_hazard = ~w_mem_stall & (hz.br_taken | w_raw);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= 8'd0;
            r_mem_err  <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (hz.mem_req && !hz.mem_ready) begin
                        r_state    <= ST_WAIT;
                        r_wait_cnt <= 8'd1;
                    end
                end
                ST_WAIT: begin
                    if (hz.mem_ready) begin
                        r_state    <= ST_RUN;
                        r_wait_cnt <= 8'd0;
                    end else if (r_wait_cnt == c_TIMEOUT) begin
                        r_state   <= ST_ERR;
                        r_mem_err <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 8'd1;
                    end
                end
                ST_ERR: begin
                    r_mem_err <= 1'b1;
                end
                default: begin
                    r_state <= ST_RUN;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_freeze && (r_stall_cnt != c_CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
            if (w_flush && (r_flush_cnt != c_CNT_MAX)) begin
                r_flush_cnt <= r_flush_cnt + 1'b1;
            end
        end
    end

    assign hz.freeze                 = w_freeze;
    assign hz.flush                  = w_flush;
    assign hz.hazard_detected_signal = w_hazard;
    assign hz.mem_stall              = w_mem_stall;
    assign hz.mem_err                = r_mem_err;
    assign hz.stall_cnt              = r_stall_cnt;
    assign hz.flush_cnt              = r_flush_cnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed self-checking bench; instance A uses defaults, instance B
//            uses FORWARD_EN=0, MEM_TIMEOUT=4, CNT_W=4.
// Revision : 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    pipe_hazard_ctrl_if #(.CNT_W(16)) ifa ();
    pipe_hazard_ctrl_if #(.CNT_W(4))  ifb ();

    pipe_hazard_ctrl #(.FORWARD_EN(1), .MEM_TIMEOUT(255), .CNT_W(16)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifa)
    );

    pipe_hazard_ctrl #(.FORWARD_EN(0), .MEM_TIMEOUT(4), .CNT_W(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_a();
        ifa.ID_src1 = 5'd0; ifa.ID_src2 = 5'd0; ifa.ID_two_src = 1'b0;
        ifa.EXE_dest = 5'd0; ifa.MEM_dest = 5'd0;
        ifa.EXE_WB_en = 1'b0; ifa.MEM_WB_en = 1'b0; ifa.EXE_MEM_read = 1'b0;
        ifa.br_taken = 1'b0; ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0;
    endtask

    task automatic clr_b();
        ifb.ID_src1 = 5'd0; ifb.ID_src2 = 5'd0; ifb.ID_two_src = 1'b0;
        ifb.EXE_dest = 5'd0; ifb.MEM_dest = 5'd0;
        ifb.EXE_WB_en = 1'b0; ifb.MEM_WB_en = 1'b0; ifb.EXE_MEM_read = 1'b0;
        ifb.br_taken = 1'b0; ifb.mem_req = 1'b0; ifb.mem_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        clr_a();
        clr_b();

        // Reset state
        #3;
        chk("rst_freeze",    32'(ifa.freeze), 32'd0);
        chk("rst_flush",     32'(ifa.flush), 32'd0);
        chk("rst_hazard",    32'(ifa.hazard_detected_signal), 32'd0);
        chk("rst_mem_stall", 32'(ifa.mem_stall), 32'd0);
        chk("rst_mem_err",   32'(ifa.mem_err), 32'd0);
        chk("rst_stall_cnt", 32'(ifa.stall_cnt), 32'd0);
        chk("rst_flush_cnt", 32'(ifa.flush_cnt), 32'd0);
        #9;
        rst_n = 1'b1;
        tick();

        // 1) Load-use hazard on A
        ifa.EXE_MEM_read = 1'b1; ifa.EXE_WB_en = 1'b1; ifa.EXE_dest = 5'd5; ifa.ID_src1 = 5'd5;
        #2;
        chk("lu_freeze", 32'(ifa.freeze), 32'd1);
        chk("lu_hazard", 32'(ifa.hazard_detected_signal), 32'd1);
        chk("lu_flush",  32'(ifa.flush), 32'd0);
        tick();
        clr_a();
        #2;
        chk("lu_release_freeze", 32'(ifa.freeze), 32'd0);
        chk("lu_stall_cnt",      32'(ifa.stall_cnt), 32'd1);
        // Non-load EXE match is forwarded when FORWARD_EN=1
        ifa.EXE_WB_en = 1'b1; ifa.EXE_dest = 5'd5; ifa.ID_src1 = 5'd5;
        #1;
        chk("fwd_nonload_freeze", 32'(ifa.freeze), 32'd0);
        chk("fwd_nonload_hazard", 32'(ifa.hazard_detected_signal), 32'd0);
        clr_a();

        // 2) RAW without forwarding on B
        ifb.MEM_WB_en = 1'b1; ifb.MEM_dest = 5'd3; ifb.ID_src2 = 5'd3; ifb.ID_two_src = 1'b1;
        #1;
        chk("raw_src2_freeze", 32'(ifb.freeze), 32'd1);
        chk("raw_src2_hazard", 32'(ifb.hazard_detected_signal), 32'd1);
        ifb.ID_two_src = 1'b0;
        #1;
        chk("raw_onesrc_freeze", 32'(ifb.freeze), 32'd0);
        chk("raw_onesrc_hazard", 32'(ifb.hazard_detected_signal), 32'd0);
        clr_b();
        ifb.EXE_WB_en = 1'b1; ifb.EXE_dest = 5'd0; ifb.ID_src1 = 5'd0;
        ifb.MEM_WB_en = 1'b1; ifb.MEM_dest = 5'd0; ifb.ID_src2 = 5'd0; ifb.ID_two_src = 1'b1;
        #1;
        chk("r0_freeze", 32'(ifb.freeze), 32'd0);
        chk("r0_hazard", 32'(ifb.hazard_detected_signal), 32'd0);
        clr_b();
        tick();

        // 3) Branch taken together with a load-use hazard on A
        ifa.br_taken = 1'b1;
        ifa.EXE_MEM_read = 1'b1; ifa.EXE_WB_en = 1'b1; ifa.EXE_dest = 5'd5; ifa.ID_src1 = 5'd5;
        #2;
        chk("br_flush",  32'(ifa.flush), 32'd1);
        chk("br_hazard", 32'(ifa.hazard_detected_signal), 32'd1);
        chk("br_freeze", 32'(ifa.freeze), 32'd0);
        tick();
        clr_a();
        #2;
        chk("br_flush_cnt", 32'(ifa.flush_cnt), 32'd1);
        chk("br_stall_cnt", 32'(ifa.stall_cnt), 32'd1);

        // mem_ready already high in RUN: no stall, no state change
        ifa.mem_req = 1'b1; ifa.mem_ready = 1'b1;
        #2;
        chk("ready_now_stall", 32'(ifa.mem_stall), 32'd0);
        tick();
        ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0;
        #2;
        chk("ready_now_run", 32'(ifa.mem_stall), 32'd0);
        tick();

        // 4) Three-cycle memory wait with a load-use hazard pending
        ifa.EXE_MEM_read = 1'b1; ifa.EXE_WB_en = 1'b1; ifa.EXE_dest = 5'd5; ifa.ID_src1 = 5'd5;
        ifa.mem_req = 1'b1; ifa.mem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk($sformatf("wait%0d_mem_stall", i), 32'(ifa.mem_stall), 32'd1);
            chk($sformatf("wait%0d_freeze", i), 32'(ifa.freeze), 32'd1);
            chk($sformatf("wait%0d_hazard", i), 32'(ifa.hazard_detected_signal), 32'd0);
            tick();
        end
        ifa.mem_ready = 1'b1;
        #2;
        chk("wait_done_mem_stall", 32'(ifa.mem_stall), 32'd0);
        chk("wait_done_hazard",    32'(ifa.hazard_detected_signal), 32'd1);
        chk("wait_done_freeze",    32'(ifa.freeze), 32'd1);
        tick();
        ifa.mem_req = 1'b0; ifa.mem_ready = 1'b0;
        #2;
        chk("back_run_mem_stall", 32'(ifa.mem_stall), 32'd0);
        chk("back_run_hazard",    32'(ifa.hazard_detected_signal), 32'd1);
        tick();
        clr_a();
        #2;
        chk("wait_stall_cnt", 32'(ifa.stall_cnt), 32'd6);

        // 5) Timeout on B: one RUN stall cycle plus four WAIT cycles, then ERR
        ifb.mem_req = 1'b1; ifb.mem_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #2;
            chk($sformatf("to%0d_mem_stall", i), 32'(ifb.mem_stall), 32'd1);
            chk($sformatf("to%0d_mem_err", i), 32'(ifb.mem_err), 32'd0);
            tick();
        end
        #2;
        chk("err_mem_stall", 32'(ifb.mem_stall), 32'd0);
        chk("err_mem_err",   32'(ifb.mem_err), 32'd1);
        chk("err_freeze",    32'(ifb.freeze), 32'd0);
        chk("err_stall_cnt", 32'(ifb.stall_cnt), 32'd5);
        ifb.mem_ready = 1'b1;
        tick();
        ifb.mem_req = 1'b0; ifb.mem_ready = 1'b0;
        #2;
        chk("err_sticky", 32'(ifb.mem_err), 32'd1);

        // 6) Saturation on B: 20 more frozen cycles on a 4-bit counter
        ifb.MEM_WB_en = 1'b1; ifb.MEM_dest = 5'd3; ifb.ID_src2 = 5'd3; ifb.ID_two_src = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        clr_b();
        #2;
        chk("sat_stall_cnt", 32'(ifb.stall_cnt), 32'd15);
        chk("sat_flush_cnt", 32'(ifb.flush_cnt), 32'd0);
        tick();

        // Async reset in the middle of a wait on A
        ifa.mem_req = 1'b1; ifa.mem_ready = 1'b0;
        tick();
        tick();
        ifa.mem_req = 1'b0;
        #2;
        chk("midwait_mem_stall", 32'(ifa.mem_stall), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_mem_stall", 32'(ifa.mem_stall), 32'd0);
        chk("arst_freeze",    32'(ifa.freeze), 32'd0);
        chk("arst_stall_cnt", 32'(ifa.stall_cnt), 32'd0);
        chk("arst_flush_cnt", 32'(ifa.flush_cnt), 32'd0);
        chk("arst_b_mem_err", 32'(ifb.mem_err), 32'd0);
        #2;
        rst_n = 1'b1;
        tick();
        #2;
        chk("post_rst_run", 32'(ifa.mem_stall), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
